// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader
//   Loads the serial configuration chain of switch-box / routing tiles.
//   Configuration words arrive over a valid/ready handshake. They are
//   shifted LSB first onto chain_data, with chain_en high for exactly
//   CHAIN_LEN shift cycles per load. Input stalls insert chain_en=0 gaps.
//
//   Optional build macro CFG_READBACK_EN adds a VERIFY pass. The chain is
//   rotated once through chain_ret, and the count of 1s returned is
//   compared against the count of 1s shifted in. Any difference sets error.
//
// Ports
//   prog_clk   configuration clock
//   rst        asynchronous, active-low reset
//   start      begin a load (sampled only in IDLE)
//   cfg_word   configuration word, LSB shifted first
//   cfg_valid  cfg_word valid
//   cfg_ready  loader accepts cfg_word this cycle
//   chain_data serial bit to first tile's prog_in
//   chain_en   shift enable to every tile's prog_en
//   chain_ret  tail tile's prog_out (used only with CFG_READBACK_EN)
//   busy       high whenever not IDLE
//   done       one-cycle completion pulse
//   error      readback mismatch flag (0 without CFG_READBACK_EN)
module cfg_chain_loader #(
   parameter int CHAIN_LEN = 32,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_word,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              chain_data,
   output logic              chain_en,
   input  logic              chain_ret,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int BW = $clog2(CHAIN_LEN + 1);
   localparam int WW = $clog2(WORD_W + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      SHIFT  = 3'd2,
`ifdef CFG_READBACK_EN
      VERIFY = 3'd3,
`endif
      DONE   = 3'd4
   } state_t;

   state_t            state;
   logic [BW-1:0]     bits_left;
   logic [WW-1:0]     wbits;
   logic [WORD_W-1:0] shreg;
   logic              en_q;
   logic              ready_q;
   logic              busy_q;
   logic              done_q;

`ifdef CFG_READBACK_EN
   logic [BW-1:0]     cnt_out;
   logic [BW-1:0]     cnt_ret;
   logic              error_q;
`endif

   // Bits taken from a freshly loaded word: the whole word, or only the
   // remainder of the chain for the final, partial word.
   function automatic logic [WW-1:0] first_wbits(input logic [BW-1:0] left);
      if (int'(left) >= WORD_W)
         return WW'(WORD_W);
      else
         return WW'(left);
   endfunction

   // cfg_ready is registered. It must be high in the cycle that shifts
   // the last bit of a word whenever more chain bits follow.
   function automatic logic ready_after(input logic [WW-1:0] w,
                                        input logic [BW-1:0] left);
      return (w == WW'(1)) && (left > BW'(1));
   endfunction

   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bits_left <= '0;
         wbits     <= '0;
         shreg     <= '0;
         en_q      <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef CFG_READBACK_EN
         cnt_out   <= '0;
         cnt_ret   <= '0;
         error_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= FETCH;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b1;
                  bits_left <= BW'(CHAIN_LEN);
`ifdef CFG_READBACK_EN
                  cnt_out   <= '0;
                  cnt_ret   <= '0;
                  error_q   <= 1'b0;
`endif
               end
            end

            FETCH: begin
               if (cfg_valid) begin
                  shreg   <= cfg_word;
                  wbits   <= first_wbits(bits_left);
                  ready_q <= ready_after(first_wbits(bits_left), bits_left);
                  en_q    <= 1'b1;
                  state   <= SHIFT;
               end
            end

            SHIFT: begin
               shreg     <= shreg >> 1;
               wbits     <= wbits - WW'(1);
               bits_left <= bits_left - BW'(1);
`ifdef CFG_READBACK_EN
               cnt_out   <= cnt_out + BW'(shreg[0]);
`endif
               if (bits_left == BW'(1)) begin
                  ready_q <= 1'b0;
`ifdef CFG_READBACK_EN
                  // Keep shifting: the chain now rotates through chain_ret.
                  state     <= VERIFY;
                  bits_left <= BW'(CHAIN_LEN);
`else
                  state  <= DONE;
                  en_q   <= 1'b0;
                  done_q <= 1'b1;
`endif
               end else if (wbits == WW'(1)) begin
                  if (cfg_valid) begin
                     // Zero-bubble reload: next word's bit 0 is presented
                     // in the very next shift cycle.
                     shreg   <= cfg_word;
                     wbits   <= first_wbits(bits_left - BW'(1));
                     ready_q <= ready_after(first_wbits(bits_left - BW'(1)),
                                            bits_left - BW'(1));
                  end else begin
                     state   <= FETCH;
                     en_q    <= 1'b0;
                     ready_q <= 1'b1;
                  end
               end else begin
                  ready_q <= ready_after(wbits - WW'(1), bits_left - BW'(1));
               end
            end

`ifdef CFG_READBACK_EN
            VERIFY: begin
               cnt_ret   <= cnt_ret + BW'(chain_ret);
               bits_left <= bits_left - BW'(1);
               if (bits_left == BW'(1)) begin
                  state   <= DONE;
                  en_q    <= 1'b0;
                  done_q  <= 1'b1;
                  // Include the bit returning in this final cycle.
                  error_q <= (cnt_out != (cnt_ret + BW'(chain_ret)));
               end
            end
`endif

            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end

            default: begin
               state   <= IDLE;
               en_q    <= 1'b0;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready = ready_q;
   assign chain_en  = en_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef CFG_READBACK_EN
   // During VERIFY the tail output is fed back to the head, so one full
   // pass of CHAIN_LEN shifts leaves every tile holding its own bit again.
   assign chain_data = (state == VERIFY) ? chain_ret : shreg[0];
   assign error      = error_q;
`else
   logic unused_ret;
   assign unused_ret = chain_ret;
   assign chain_data = shreg[0];
   assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader
//   Directed bench for cfg_chain_loader. It uses two instances: a 32-bit
//   chain and a 20-bit chain, both with WORD_W=8. Each chain is modelled
//   as a plain shift register: the tail is bit 0, and new bits enter at the
//   top. Build with CFG_READBACK_EN defined to cover the readback variant.
module tb_cfg_chain_loader;

`ifdef CFG_READBACK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif

   // Expected cycle numbers. Cycle 0 is the cycle whose closing edge
   // samples start; cycle n closes at edge n. A load spends one cycle in
   // FETCH, then CHAIN_LEN cycles in SHIFT, then one cycle in DONE.
   localparam int DONE_A     = 34 + RB * 32;
   localparam int DONE_A_GAP = 43 + RB * 32;
   localparam int DONE_B     = 22 + RB * 20;
   localparam int EN_A       = 32 * (1 + RB);
   localparam int EN_B       = 20 * (1 + RB);
   localparam int RUN_A_GAP  = 8 + RB * 32;

   logic       prog_clk;
   logic       rst;

   logic       a_start, a_valid, a_ready, a_data, a_en, a_ret, a_busy, a_done, a_err;
   logic [7:0] a_word;
   logic       b_start, b_valid, b_ready, b_data, b_en, b_ret, b_busy, b_done, b_err;
   logic [7:0] b_word;

   logic [31:0] chain_a;
   logic [19:0] chain_b;
   logic        stuck;
   logic [7:0]  wa [4];
   logic [7:0]  wb [3];

   int nchecks;
   int nerr;

   cfg_chain_loader #(.CHAIN_LEN(32), .WORD_W(8)) dut_a (
      .prog_clk   (prog_clk),
      .rst        (rst),
      .start      (a_start),
      .cfg_word   (a_word),
      .cfg_valid  (a_valid),
      .cfg_ready  (a_ready),
      .chain_data (a_data),
      .chain_en   (a_en),
      .chain_ret  (a_ret),
      .busy       (a_busy),
      .done       (a_done),
      .error      (a_err)
   );

   cfg_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (
      .prog_clk   (prog_clk),
      .rst        (rst),
      .start      (b_start),
      .cfg_word   (b_word),
      .cfg_valid  (b_valid),
      .cfg_ready  (b_ready),
      .chain_data (b_data),
      .chain_en   (b_en),
      .chain_ret  (b_ret),
      .busy       (b_busy),
      .done       (b_done),
      .error      (b_err)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   // Tile chain models. They share rst with the loaders.
   always @(posedge prog_clk or negedge rst) begin
      if (!rst) chain_a <= '0;
      else if (a_en) chain_a <= {a_data, chain_a[31:1]};
   end
   always @(posedge prog_clk or negedge rst) begin
      if (!rst) chain_b <= '0;
      else if (b_en) chain_b <= {b_data, chain_b[19:1]};
   end
   assign a_ret = chain_a[0] & ~stuck;
   assign b_ret = chain_b[0];

   task automatic check(input string tag, input int got, input int exp);
      nchecks++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_wa(input logic [31:0] v);
      for (int i = 0; i < 4; i++) wa[i] = v[8*i +: 8];
   endtask

   // Runs one load on instance A.
   //   gap: valid is withheld for this many ready cycles after each handshake.
   //   pulse_at: cycle in which start is pulsed again (0 = never).
   //   rst_at: cycle in which rst is asserted and the task returns (0 = never).
   task automatic load_a(input int gap, input int pulse_at, input int rst_at,
                         input int budget, output int done_cyc, output int en_hi,
                         output int max_run, output int hs, output int ndone,
                         output int err1);
      int idx, wait_c, run;
      idx = 0; wait_c = 0; run = 0;
      done_cyc = 0; en_hi = 0; max_run = 0; hs = 0; ndone = 0; err1 = 0;
      @(negedge prog_clk);
      a_start = 1'b1;
      for (int c = 1; c <= budget; c++) begin
         @(negedge prog_clk);
         a_start = (c == pulse_at);
         if (c == 1) err1 = int'(a_err);
         if (c == rst_at) begin
            rst = 1'b0;
            a_valid = 1'b0;
            #1;
            check("rst_outs_a", int'({a_ready, a_data, a_en, a_busy, a_done, a_err}), 0);
            check("rst_chain_a", int'(chain_a), 0);
            repeat (3) @(negedge prog_clk);
            check("rst_hold_done", int'({a_done, a_busy}), 0);
            rst = 1'b1;
            return;
         end
         if (wait_c > 0) begin
            a_valid = 1'b0;
            if (a_ready) wait_c--;
         end else begin
            a_valid = (idx < 4);
            a_word  = (idx < 4) ? wa[idx] : 8'h00;
         end
         if (a_valid && a_ready) begin
            hs++; idx++; wait_c = gap;
         end
         if (a_en) begin
            en_hi++; run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (a_done) begin
            ndone++;
            if (done_cyc == 0) done_cyc = c;
         end
      end
      a_valid = 1'b0;
   endtask

   task automatic load_b(input int budget, output int done_cyc, output int en_hi,
                         output int hs, output int ndone);
      int idx;
      idx = 0; done_cyc = 0; en_hi = 0; hs = 0; ndone = 0;
      @(negedge prog_clk);
      b_start = 1'b1;
      for (int c = 1; c <= budget; c++) begin
         @(negedge prog_clk);
         b_start = 1'b0;
         b_valid = (idx < 3);
         b_word  = (idx < 3) ? wb[idx] : 8'h00;
         if (b_valid && b_ready) begin hs++; idx++; end
         if (b_en) en_hi++;
         if (b_done) begin
            ndone++;
            if (done_cyc == 0) done_cyc = c;
         end
      end
      b_valid = 1'b0;
   endtask

   initial begin
      int dc, en, mr, hs, nd, e1;
      nchecks = 0; nerr = 0;
      rst = 1'b0; stuck = 1'b0;
      a_start = 1'b0; a_valid = 1'b0; a_word = '0;
      b_start = 1'b0; b_valid = 1'b0; b_word = '0;
      #2;
      check("reset_outs_a", int'({a_ready, a_data, a_en, a_busy, a_done, a_err}), 0);
      check("reset_outs_b", int'({b_ready, b_data, b_en, b_busy, b_done, b_err}), 0);
      repeat (2) @(negedge prog_clk);
      rst = 1'b1;

      // Back-to-back words, valid always available.
      set_wa(32'h44332211);
      load_a(0, 0, 0, DONE_A + 8, dc, en, mr, hs, nd, e1);
      check("t1_done_cycle", dc, DONE_A);
      check("t1_en_count", en, EN_A);
      check("t1_en_run", mr, EN_A);
      check("t1_handshakes", hs, 4);
      check("t1_done_count", nd, 1);
      check("t1_chain", int'(chain_a), 32'h44332211);
      check("t1_busy_after", int'(a_busy), 0);
      check("t1_error", int'(a_err), 0);

      // Three-cycle valid gaps between words.
      load_a(3, 0, 0, DONE_A_GAP + 8, dc, en, mr, hs, nd, e1);
      check("t2_done_cycle", dc, DONE_A_GAP);
      check("t2_en_count", en, EN_A);
      check("t2_en_run", mr, RUN_A_GAP);
      check("t2_handshakes", hs, 4);
      check("t2_chain", int'(chain_a), 32'h44332211);

      // Short chain with a partial final word.
      wb[0] = 8'hA5; wb[1] = 8'h3C; wb[2] = 8'hFF;
      load_b(DONE_B + 8, dc, en, hs, nd);
      check("t3_done_cycle", dc, DONE_B);
      check("t3_en_count", en, EN_B);
      check("t3_handshakes", hs, 3);
      check("t3_done_count", nd, 1);
      check("t3_chain", int'(chain_b), 20'hF3CA5);
      check("t3_busy_after", int'(b_busy), 0);

      // Reset after ten shifted bits, then a clean load.
      load_a(0, 0, 12, DONE_A + 8, dc, en, mr, hs, nd, e1);
      check("t4_en_before_rst", en, 10);
      check("t4_no_done", nd, 0);
      repeat (3) begin
         @(negedge prog_clk);
         check("t4_idle_after_rst", int'({a_busy, a_done, a_en}), 0);
      end
      set_wa(32'hDEADBEEF);
      load_a(0, 0, 0, DONE_A + 8, dc, en, mr, hs, nd, e1);
      check("t4_done_count", nd, 1);
      check("t4_chain", int'(chain_a), 32'hDEADBEEF);

      // start pulsed mid-load must not restart.
      set_wa(32'h44332211);
      load_a(0, 10, 0, DONE_A + 12, dc, en, mr, hs, nd, e1);
      check("t5_done_count", nd, 1);
      check("t5_done_cycle", dc, DONE_A);
      check("t5_en_count", en, EN_A);
      check("t5_chain", int'(chain_a), 32'h44332211);
      check("t5_busy_after", int'(a_busy), 0);

`ifdef CFG_READBACK_EN
      set_wa(32'h0F0F0F0F);
      load_a(0, 0, 0, DONE_A + 8, dc, en, mr, hs, nd, e1);
      check("rb_ok_error", int'(a_err), 0);
      check("rb_ok_chain", int'(chain_a), 32'h0F0F0F0F);
      stuck = 1'b1;
      load_a(0, 0, 0, DONE_A + 8, dc, en, mr, hs, nd, e1);
      check("rb_stuck_error", int'(a_err), 1);
      repeat (5) @(negedge prog_clk);
      check("rb_error_held", int'(a_err), 1);
      stuck = 1'b0;
      load_a(0, 0, 0, DONE_A + 8, dc, en, mr, hs, nd, e1);
      check("rb_error_cleared_on_start", e1, 0);
      check("rb_final_error", int'(a_err), 0);
      check("rb_final_chain", int'(chain_a), 32'h0F0F0F0F);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
